// File: rtl/spm_arbiter.sv
// SPM port B arbiter: fixed-priority MEM with a starvation-guaranteed DMA slot and read-return routing.
// Optional build macro SPM_ARB_STAT_EN adds saturating grant/stall statistics counters.
module spm_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_as_,
  input  logic        mem_rw,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  output logic [31:0] mem_rd_data,
  output logic        mem_busy,
  input  logic        dma_req,
  input  logic        dma_rw,
  input  logic [29:0] dma_addr,
  input  logic [31:0] dma_wr_data,
  output logic        dma_gnt,
  output logic [31:0] dma_rd_data,
  output logic        dma_rd_valid,
  output logic        spm_as_,
  output logic        spm_rw,
  output logic [29:0] spm_addr,
  output logic [31:0] spm_wr_data,
`ifdef SPM_ARB_STAT_EN
  output logic [15:0] stat_dma_gnt,
  output logic [15:0] stat_mem_stall,
`endif
  input  logic [31:0] spm_rd_data
);

  localparam int unsigned STAT_W = 16;

  typedef enum logic {
    ST_NORMAL,
    ST_FORCE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_MEM,
    OWN_DMA
  } owner_t;

  state_t              state, state_next;
  owner_t              rd_owner, rd_owner_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                mem_gnt;

  // Grant decode: same-cycle, so MEM sees no added latency.
  always_comb begin
    state_next = state;
    mem_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    mem_busy   = 1'b0;
    if (!reset) begin
      case (state)
        ST_NORMAL: begin
          if (!mem_as_) begin
            mem_gnt = 1'b1;
          end else if (dma_req) begin
            dma_gnt = 1'b1;
          end
          if (dma_req && !dma_gnt && (wait_cnt == WAIT_W'(MAX_WAIT - 1))) begin
            state_next = ST_FORCE;
          end
        end
        ST_FORCE: begin
          state_next = ST_NORMAL;
          if (dma_req) begin
            dma_gnt  = 1'b1;
            mem_busy = !mem_as_;
          end else if (!mem_as_) begin
            mem_gnt = 1'b1;
          end
        end
        default: state_next = ST_NORMAL;
      endcase
    end
  end

  // Port B mux; idle bus is held at zero.
  always_comb begin
    spm_as_     = 1'b1;
    spm_rw      = 1'b0;
    spm_addr    = '0;
    spm_wr_data = '0;
    if (mem_gnt) begin
      spm_as_     = 1'b0;
      spm_rw      = mem_rw;
      spm_addr    = mem_addr;
      spm_wr_data = mem_wr_data;
    end else if (dma_gnt) begin
      spm_as_     = 1'b0;
      spm_rw      = dma_rw;
      spm_addr    = dma_addr;
      spm_wr_data = dma_wr_data;
    end
  end

  always_comb begin
    rd_owner_next = OWN_NONE;
    if (mem_gnt && mem_rw) begin
      rd_owner_next = OWN_MEM;
    end else if (dma_gnt && dma_rw) begin
      rd_owner_next = OWN_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_NORMAL;
      rd_owner <= OWN_NONE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      rd_owner <= rd_owner_next;
      if (dma_gnt || !dma_req) begin
        wait_cnt <= '0;
      end else if (wait_cnt != {WAIT_W{1'b1}}) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Return data follows the owner recorded at grant time, not the current grant.
  always_comb begin
    mem_rd_data  = '0;
    dma_rd_data  = '0;
    dma_rd_valid = 1'b0;
    if (!reset) begin
      if (rd_owner == OWN_MEM) begin
        mem_rd_data = spm_rd_data;
      end else if (rd_owner == OWN_DMA) begin
        dma_rd_data  = spm_rd_data;
        dma_rd_valid = 1'b1;
      end
    end
  end

`ifdef SPM_ARB_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_dma_gnt   <= '0;
      stat_mem_stall <= '0;
    end else begin
      if (dma_gnt && (stat_dma_gnt != {STAT_W{1'b1}})) begin
        stat_dma_gnt <= stat_dma_gnt + STAT_W'(1);
      end
      if (mem_busy && (stat_mem_stall != {STAT_W{1'b1}})) begin
        stat_mem_stall <= stat_mem_stall + STAT_W'(1);
      end
    end
  end
`endif

endmodule
